// File: rtl/nibble_bus_ctrl_pkg.sv
// Shared constants for the nibble bus sequencer: state encodings, bus width
// and the default register-bank geometry.
package nibble_bus_ctrl_pkg;

    localparam int NIBBLE_W  = 4;
    localparam int NREGS_DEF = 4;
    localparam int SELW_DEF  = 2;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DRIVE   = 2'd1;
    localparam logic [1:0] ST_LATCH   = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

endpackage

// File: rtl/nibble_bus_ctrl_onehot_dec.sv
// Index-to-one-hot decoder with enable.
// An index outside the register bank decodes to all zeros.
module nibble_onehot_dec #(
    parameter int NREGS = 4,
    parameter int SELW  = 2
) (
    input  logic [SELW-1:0]  idx_i,
    input  logic             en_i,
    output logic [NREGS-1:0] onehot_o
);

    // Compare against each bank position so out-of-range indices never select a bit
    always_comb begin
        onehot_o = '0;
        for (int i = 0; i < NREGS; i++) begin
            onehot_o[i] = en_i && (idx_i == SELW'(i));
        end
    end

endmodule

// File: rtl/nibble_bus_ctrl.sv
// Sequencer for a shared tri-state nibble bus: drives one source register onto
// the bus, lets it settle, strobes the destination load, then releases the bus.
module nibble_bus_ctrl
    import nibble_bus_ctrl_pkg::*;
#(
    parameter int NREGS  = NREGS_DEF,
    parameter int SELW   = SELW_DEF,
    parameter int SETTLE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic [SELW-1:0]     src_sel,
    input  logic [SELW-1:0]     dst_sel,
    input  logic [NIBBLE_W-1:0] bus_in,
    output logic [NREGS-1:0]    out_en,
    output logic [NREGS-1:0]    load,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [NIBBLE_W-1:0] captured
);

    logic [1:0]          state_q, state_d;
    logic [SELW-1:0]     src_q, src_d;
    logic [SELW-1:0]     dst_q, dst_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                err_d;
    logic                sel_ok_s;
    logic                drive_en_s;
    logic                load_en_s;
    logic [NREGS-1:0]    out_en_s;
    logic [NREGS-1:0]    load_s;
    logic [NREGS-1:0]    out_en_q;
    logic [NREGS-1:0]    load_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [NIBBLE_W-1:0] captured_q;

    assign sel_ok_s = (int'(src_sel) < NREGS) && (int'(dst_sel) < NREGS)
                      && (src_sel != dst_sel);

    // Transfer sequencing and request acceptance
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (sel_ok_s) begin
                        src_d   = src_sel;
                        dst_d   = dst_sel;
                        cnt_d   = 4'(SETTLE - 1);
                        state_d = ST_DRIVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_LATCH;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_LATCH:   state_d = ST_RELEASE;
            ST_RELEASE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    assign drive_en_s = (state_q == ST_DRIVE) || (state_q == ST_LATCH);
    assign load_en_s  = (state_q == ST_LATCH);

    nibble_onehot_dec #(.NREGS(NREGS), .SELW(SELW)) u_out_en_dec (
        .idx_i    (src_q),
        .en_i     (drive_en_s),
        .onehot_o (out_en_s)
    );

    nibble_onehot_dec #(.NREGS(NREGS), .SELW(SELW)) u_load_dec (
        .idx_i    (dst_q),
        .en_i     (load_en_s),
        .onehot_o (load_s)
    );

    // State, latched selects and registered bus-control outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            cnt_q      <= 4'd0;
            out_en_q   <= '0;
            load_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            captured_q <= '0;
        end else begin
            state_q  <= state_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            cnt_q    <= cnt_d;
            out_en_q <= out_en_s;
            load_q   <= load_s;
            busy_q   <= (state_q != ST_IDLE);
            done_q   <= (state_q == ST_RELEASE);
            err_q    <= err_d;
            // Snapshot the bus on the same edge the destination register loads
            if (|load_q) begin
                captured_q <= bus_in;
            end else begin
                captured_q <= captured_q;
            end
        end
    end

    assign out_en   = out_en_q;
    assign load     = load_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign captured = captured_q;

endmodule

// File: tb/tb_nibble_bus_ctrl.sv
// Directed bench for nibble_bus_ctrl: one instance with SETTLE=1, one with SETTLE=3.
module tb_nibble_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_a, req_b;
    logic [1:0] src_a, dst_a, src_b, dst_b;
    logic [3:0] bus_a, bus_b;
    logic [3:0] out_en_a, load_a, captured_a;
    logic [3:0] out_en_b, load_b, captured_b;
    logic       busy_a, done_a, err_a, busy_b, done_b, err_b;
    logic [1:0] src_exp_a, src_exp_b;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    nibble_bus_ctrl #(.NREGS(4), .SELW(2), .SETTLE(1)) dut_a (
        .clk(clk), .reset(reset), .req(req_a), .src_sel(src_a), .dst_sel(dst_a),
        .bus_in(bus_a), .out_en(out_en_a), .load(load_a), .busy(busy_a),
        .done(done_a), .err(err_a), .captured(captured_a)
    );

    nibble_bus_ctrl #(.NREGS(4), .SELW(2), .SETTLE(3)) dut_b (
        .clk(clk), .reset(reset), .req(req_b), .src_sel(src_b), .dst_sel(dst_b),
        .bus_in(bus_b), .out_en(out_en_b), .load(load_b), .busy(busy_b),
        .done(done_b), .err(err_b), .captured(captured_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus-enable invariants, sampled every cycle away from the active edge
    always @(negedge clk) begin
        chk("inv_a_onehot", 8'($countones(out_en_a) <= 1), 8'd1);
        chk("inv_b_onehot", 8'($countones(out_en_b) <= 1), 8'd1);
        chk("inv_a_load_src", 8'((load_a == 4'd0) || (out_en_a[src_exp_a] === 1'b1)), 8'd1);
        chk("inv_b_load_src", 8'((load_b == 4'd0) || (out_en_b[src_exp_b] === 1'b1)), 8'd1);
    end

    initial begin
        req_a = 1'b0; src_a = 2'd0; dst_a = 2'd0; bus_a = 4'h0;
        req_b = 1'b0; src_b = 2'd0; dst_b = 2'd0; bus_b = 4'h0;
        src_exp_a = 2'd0; src_exp_b = 2'd0;

        #2;
        chk("rst_out_en", 8'(out_en_a), 8'h00);
        chk("rst_load", 8'(load_a), 8'h00);
        chk("rst_busy", 8'(busy_a), 8'h00);
        chk("rst_done", 8'(done_a), 8'h00);
        chk("rst_err", 8'(err_a), 8'h00);
        chk("rst_captured", 8'(captured_a), 8'h00);
        chk("rst_b_out_en", 8'(out_en_b), 8'h00);
        @(negedge clk);
        reset = 1'b0;

        // Transfer 1 -> 2 with SETTLE=1
        src_a = 2'd1; dst_a = 2'd2; bus_a = 4'hA; req_a = 1'b1; src_exp_a = 2'd1;
        @(negedge clk);
        req_a = 1'b0;
        chk("t1_e0_out_en", 8'(out_en_a), 8'h00);
        chk("t1_e0_busy", 8'(busy_a), 8'h00);
        @(negedge clk);
        chk("t1_e1_out_en", 8'(out_en_a), 8'h02);
        chk("t1_e1_load", 8'(load_a), 8'h00);
        chk("t1_e1_busy", 8'(busy_a), 8'h01);
        @(negedge clk);
        chk("t1_e2_out_en", 8'(out_en_a), 8'h02);
        chk("t1_e2_load", 8'(load_a), 8'h04);
        chk("t1_e2_done", 8'(done_a), 8'h00);
        chk("t1_e2_busy", 8'(busy_a), 8'h01);
        @(negedge clk);
        chk("t1_e3_out_en", 8'(out_en_a), 8'h00);
        chk("t1_e3_load", 8'(load_a), 8'h00);
        chk("t1_e3_done", 8'(done_a), 8'h01);
        chk("t1_e3_busy", 8'(busy_a), 8'h01);
        chk("t1_e3_captured", 8'(captured_a), 8'h0A);
        @(negedge clk);
        chk("t1_e4_done", 8'(done_a), 8'h00);
        chk("t1_e4_busy", 8'(busy_a), 8'h00);

        // Rejected request: src == dst
        src_a = 2'd3; dst_a = 2'd3; bus_a = 4'h5; req_a = 1'b1;
        @(negedge clk);
        req_a = 1'b0;
        chk("t2_err", 8'(err_a), 8'h01);
        chk("t2_out_en", 8'(out_en_a), 8'h00);
        chk("t2_load", 8'(load_a), 8'h00);
        chk("t2_busy", 8'(busy_a), 8'h00);
        chk("t2_captured", 8'(captured_a), 8'h0A);
        @(negedge clk);
        chk("t2_err_clr", 8'(err_a), 8'h00);
        chk("t2_out_en2", 8'(out_en_a), 8'h00);
        chk("t2_busy2", 8'(busy_a), 8'h00);

        // Transfer 0 -> 3 with SETTLE=3, plus an ignored request mid-transfer
        src_b = 2'd0; dst_b = 2'd3; bus_b = 4'hF; req_b = 1'b1; src_exp_b = 2'd0;
        @(negedge clk);
        req_b = 1'b0;
        chk("t3_e0_out_en", 8'(out_en_b), 8'h00);
        @(negedge clk);
        chk("t3_e1_out_en", 8'(out_en_b), 8'h01);
        chk("t3_e1_load", 8'(load_b), 8'h00);
        chk("t3_e1_busy", 8'(busy_b), 8'h01);
        req_b = 1'b1; src_b = 2'd2; dst_b = 2'd0;
        @(negedge clk);
        chk("t3_e2_out_en", 8'(out_en_b), 8'h01);
        chk("t3_e2_load", 8'(load_b), 8'h00);
        @(negedge clk);
        chk("t3_e3_out_en", 8'(out_en_b), 8'h01);
        chk("t3_e3_load", 8'(load_b), 8'h00);
        req_b = 1'b0;
        @(negedge clk);
        chk("t3_e4_out_en", 8'(out_en_b), 8'h01);
        chk("t3_e4_load", 8'(load_b), 8'h08);
        @(negedge clk);
        chk("t3_e5_out_en", 8'(out_en_b), 8'h00);
        chk("t3_e5_load", 8'(load_b), 8'h00);
        chk("t3_e5_done", 8'(done_b), 8'h01);
        chk("t3_e5_captured", 8'(captured_b), 8'h0F);
        @(negedge clk);
        chk("t3_e6_done", 8'(done_b), 8'h00);
        chk("t3_e6_busy", 8'(busy_b), 8'h00);
        chk("t3_e6_out_en", 8'(out_en_b), 8'h00);
        @(negedge clk);
        chk("t3_e7_out_en", 8'(out_en_b), 8'h00);
        chk("t3_e7_busy", 8'(busy_b), 8'h00);
        chk("t3_e7_done", 8'(done_b), 8'h00);

        // Reset asserted while load is strobing
        src_a = 2'd0; dst_a = 2'd1; bus_a = 4'h5; req_a = 1'b1; src_exp_a = 2'd0;
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        chk("t4_e1_out_en", 8'(out_en_a), 8'h01);
        @(negedge clk);
        chk("t4_e2_out_en", 8'(out_en_a), 8'h01);
        chk("t4_e2_load", 8'(load_a), 8'h02);
        #2 reset = 1'b1;
        #1;
        chk("t4_rst_out_en", 8'(out_en_a), 8'h00);
        chk("t4_rst_load", 8'(load_a), 8'h00);
        chk("t4_rst_busy", 8'(busy_a), 8'h00);
        chk("t4_rst_captured", 8'(captured_a), 8'h00);
        @(negedge clk);
        chk("t4_rst_done", 8'(done_a), 8'h00);
        chk("t4_rst_out_en2", 8'(out_en_a), 8'h00);
        reset = 1'b0;

        // Normal transfer after reset: 3 -> 0
        src_a = 2'd3; dst_a = 2'd0; bus_a = 4'h6; req_a = 1'b1; src_exp_a = 2'd3;
        @(negedge clk);
        req_a = 1'b0;
        @(negedge clk);
        chk("t5_e1_out_en", 8'(out_en_a), 8'h08);
        @(negedge clk);
        chk("t5_e2_out_en", 8'(out_en_a), 8'h08);
        chk("t5_e2_load", 8'(load_a), 8'h01);
        @(negedge clk);
        chk("t5_e3_done", 8'(done_a), 8'h01);
        chk("t5_e3_captured", 8'(captured_a), 8'h06);
        @(negedge clk);
        chk("t5_e4_done", 8'(done_a), 8'h00);
        chk("t5_e4_busy", 8'(busy_a), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
